window_cmd_arbiter: RTL
=======================

WINDOW_CMD_ARBITER -- requirements
Module: window_cmd_arbiter

Interface
REQ-001 Parameter DEBOUNCE_MS, default 20: consecutive stable cycles (1 ms each at 1 kHz) required to accept a button press or release.
REQ-002 Parameter GAP_CYCLES, default 2: idle cycles enforced after every issued command pulse.
REQ-003 Parameter LOCKOUT_MS, default 2000: cycles during which all requests are ignored after a pinch event.
REQ-004 SYSCLK  input  1  system clock, 1 kHz, all logic on rising edge.
REQ-005 RST_N  input  1  reset, asynchronous, active-low.
REQ-006 drv_up, drv_down  input  1 each  driver panel buttons, raw, asynchronous, high = pressed.
REQ-007 psg_up, psg_down  input  1 each  passenger panel buttons, raw, asynchronous, high = pressed.
REQ-008 rmt_close  input  1  remote-key close request, raw, high = pressed.
REQ-009 child_lock  input  1  high = passenger panel disabled.
REQ-010 stop_signal  input  1  pressure-sensor pinch indication, high = obstruction.
REQ-011 INM  input  2  motor drive state feedback: 00 idle, 01 closing (up), 10 opening (down), 11 brake.
REQ-012 s_c_up  output  1  one-cycle up/stop command pulse to the anti-pinch motor controller.
REQ-013 s_c_down  output  1  one-cycle down/stop command pulse to the anti-pinch motor controller.
REQ-014 grant  output  2  source of the current pulse: 00 none, 01 driver, 10 passenger, 11 remote; nonzero only in the pulse cycle.
REQ-015 pinch_lock  output  1  high throughout LOCKOUT.
REQ-016 busy  output  1  high whenever FSM is not IDLE.

Function
REQ-017 Each of the five raw buttons SHALL pass through a 2-flop synchronizer, then a debouncer that changes its debounced level only after DEBOUNCE_MS consecutive cycles of the opposite synchronized level.
REQ-018 A debounced 0->1 transition SHALL set that button's pending flag on the next edge; 1->0 transitions SHALL produce no event.
REQ-019 Same-source up and down pending flags set together SHALL both be discarded.
REQ-020 While child_lock=1, passenger events SHALL not be latched, and existing passenger pending flags SHALL clear on the next edge.
REQ-021 FSM states: IDLE, ISSUE, GAP, LOCKOUT; all outputs registered.
REQ-022 IDLE -> ISSUE when any pending flag is set; priority driver > remote > passenger; within a source, only one direction can be pending (REQ-019).
REQ-023 ISSUE lasts exactly one cycle: the winner's s_c_up or s_c_down = 1 and grant = the source code; the winner's pending flag clears; losers stay pending.
REQ-024 If rmt_close wins while INM=01, no pulse SHALL be issued (grant=00) and the flag SHALL clear, so the remote never stops a closing window; driver/passenger pulses are issued regardless of INM.
REQ-025 ISSUE -> GAP; GAP lasts GAP_CYCLES cycles, then -> IDLE.
REQ-026 Idle latency: s_c_up/s_c_down SHALL rise exactly DEBOUNCE_MS+4 edges after the first edge that samples the raw button high, with the button held stable.
REQ-027 Pinch event = synchronized stop_signal 0->1 while INM=01; in any state it SHALL force LOCKOUT on the next edge, clear all pending flags, and suppress any pulse decided in the same cycle.
REQ-028 stop_signal rising while INM!=01 SHALL be ignored.
REQ-029 LOCKOUT: pinch_lock=1; debouncers keep running but no events are latched; after LOCKOUT_MS cycles -> IDLE with pinch_lock=0. A further pinch event during LOCKOUT SHALL restart the count.
REQ-030 At most one of s_c_up, s_c_down SHALL be high in any cycle; neither SHALL be high on two consecutive cycles.

Reset
REQ-031 RST_N low SHALL immediately force: FSM=IDLE, s_c_up=0, s_c_down=0, grant=00, pinch_lock=0, busy=0, all pending flags, counters and synchronizers 0, debounced levels 0.
REQ-032 A button held through reset release SHALL be treated as a new press and yield one pulse per REQ-026.

Verification
REQ-033 Hold drv_up high for 30 cycles, INM=00 -> exactly one s_c_up pulse at edge 24, grant=01, busy high for 3 cycles.
REQ-034 drv_down and psg_up pressed on the same edge, child_lock=0 -> s_c_down with grant=01 first, s_c_up with grant=10 exactly 3 cycles later.
REQ-035 psg_down held 30 cycles with child_lock=1 -> no pulse, grant stays 00.
REQ-036 rmt_close press with INM=01 -> no pulse; same press with INM=00 -> s_c_up with grant=11.
REQ-037 INM=01, stop_signal 0->1 with drv_down pending -> pinch_lock high for 2000 cycles, pending drv_down discarded, no pulse; a drv_up press during lockout yields nothing.
REQ-038 RST_N pulsed low mid-GAP -> all outputs 0 asynchronously; drv_up still held -> one new pulse DEBOUNCE_MS+4 edges after reset release.

Source files
------------

// File: rtl/window_cmd_arbiter_if.sv
// Signal bundle between the window command arbiter and its environment:
// raw panel/remote requests, safety inputs, motor feedback and command outputs.
interface window_cmd_arbiter_if;
    logic       drv_up;
    logic       drv_down;
    logic       psg_up;
    logic       psg_down;
    logic       rmt_close;
    logic       child_lock;
    logic       stop_signal;
    logic [1:0] INM;
    logic       s_c_up;
    logic       s_c_down;
    logic [1:0] grant;
    logic       pinch_lock;
    logic       busy;

    // Environment side: drives requests and feedback, observes commands.
    modport master (
        output drv_up, drv_down, psg_up, psg_down, rmt_close,
        output child_lock, stop_signal, INM,
        input  s_c_up, s_c_down, grant, pinch_lock, busy
    );

    // Arbiter side.
    modport slave (
        input  drv_up, drv_down, psg_up, psg_down, rmt_close,
        input  child_lock, stop_signal, INM,
        output s_c_up, s_c_down, grant, pinch_lock, busy
    );
endinterface

// File: rtl/window_cmd_arbiter.sv
// Window command arbiter: synchronizes and debounces five window buttons,
// latches press events, and issues spaced one-cycle up/down command pulses
// to the anti-pinch motor controller, with a pinch-triggered lockout.
module window_cmd_arbiter #(
    parameter int unsigned DEBOUNCE_MS = 20,
    parameter int unsigned GAP_CYCLES  = 2,
    parameter int unsigned LOCKOUT_MS  = 2000
) (
    input logic                 SYSCLK,
    input logic                 RST_N,
    window_cmd_arbiter_if.slave bus
);

    localparam int unsigned NumBtn = 5;
    localparam int unsigned DbW    = $clog2(DEBOUNCE_MS) + 1;
    localparam int unsigned GapW   = $clog2(GAP_CYCLES) + 1;
    localparam int unsigned LkW    = $clog2(LOCKOUT_MS) + 1;

    // Button bit positions.
    localparam int unsigned BDrvUp = 0;
    localparam int unsigned BDrvDn = 1;
    localparam int unsigned BPsgUp = 2;
    localparam int unsigned BPsgDn = 3;
    localparam int unsigned BRmt   = 4;

    localparam logic [NumBtn-1:0] PsgMask = 5'b01100;

    localparam logic [1:0] InmClosing = 2'b01;
    localparam logic [1:0] GntNone    = 2'b00;
    localparam logic [1:0] GntDrv     = 2'b01;
    localparam logic [1:0] GntPsg     = 2'b10;
    localparam logic [1:0] GntRmt     = 2'b11;

    typedef enum logic [1:0] {StIdle, StIssue, StGap, StLockout} state_e;

    logic [NumBtn-1:0] btn_raw;
    logic [NumBtn-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
    logic [NumBtn-1:0] deb_q, deb_d, deb_prev_q, deb_prev_d;
    logic [DbW-1:0]    cnt_q [NumBtn];
    logic [DbW-1:0]    cnt_d [NumBtn];
    logic [NumBtn-1:0] rise;
    logic [NumBtn-1:0] pend_q, pend_d, pend_eff;

    logic stop_s1_q, stop_s1_d, stop_s2_q, stop_s2_d, stop_prev_q, stop_prev_d;
    logic pinch;

    state_e            state_q, state_d;
    logic [GapW-1:0]   gap_cnt_q, gap_cnt_d;
    logic [LkW-1:0]    lock_cnt_q, lock_cnt_d;
    logic              arb;

    logic       s_c_up_q, s_c_up_d, s_c_down_q, s_c_down_d;
    logic [1:0] grant_q, grant_d;
    logic       pinch_lock_q, pinch_lock_d, busy_q, busy_d;

    assign btn_raw = {bus.rmt_close, bus.psg_down, bus.psg_up, bus.drv_down, bus.drv_up};

    // Two-flop synchronizers for buttons and the pressure sensor; edge history.
    always_comb begin
        sync1_d     = btn_raw;
        sync2_d     = sync1_q;
        deb_prev_d  = deb_q;
        stop_s1_d   = bus.stop_signal;
        stop_s2_d   = stop_s1_q;
        stop_prev_d = stop_s2_q;
    end

    // Debounce: flip the level only after DEBOUNCE_MS consecutive opposite samples.
    always_comb begin
        for (int i = 0; i < NumBtn; i++) begin
            deb_d[i] = deb_q[i];
            cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == DbW'(DEBOUNCE_MS - 1)) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign rise  = deb_q & ~deb_prev_q;
    assign pinch = stop_s2_q & ~stop_prev_q & (bus.INM == InmClosing);
    // Passenger flags are invisible to arbitration while the child lock is on.
    assign pend_eff = bus.child_lock ? (pend_q & ~PsgMask) : pend_q;

    // Arbiter FSM next state, pending-flag update and registered output values.
    always_comb begin
        state_d    = state_q;
        gap_cnt_d  = gap_cnt_q;
        lock_cnt_d = lock_cnt_q;
        pend_d     = pend_q;
        s_c_up_d   = 1'b0;
        s_c_down_d = 1'b0;
        grant_d    = GntNone;
        arb        = 1'b0;

        case (state_q)
            StIdle: arb = 1'b1;
            StIssue: begin
                state_d   = StGap;
                gap_cnt_d = '0;
            end
            StGap: begin
                // Last gap cycle arbitrates directly so pulses are spaced by
                // exactly GAP_CYCLES idle cycles.
                if (gap_cnt_q == GapW'(GAP_CYCLES - 1)) begin
                    state_d = StIdle;
                    arb     = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            StLockout: begin
                if (lock_cnt_q == LkW'(LOCKOUT_MS - 1)) begin
                    state_d = StIdle;
                end else begin
                    lock_cnt_d = lock_cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // Priority: driver > remote > passenger.
        if (arb && (|pend_eff)) begin
            state_d = StIssue;
            if (pend_eff[BDrvUp]) begin
                s_c_up_d       = 1'b1;
                grant_d        = GntDrv;
                pend_d[BDrvUp] = 1'b0;
            end else if (pend_eff[BDrvDn]) begin
                s_c_down_d     = 1'b1;
                grant_d        = GntDrv;
                pend_d[BDrvDn] = 1'b0;
            end else if (pend_eff[BRmt]) begin
                // Remote close must never stop a window that is already closing.
                pend_d[BRmt] = 1'b0;
                if (bus.INM != InmClosing) begin
                    s_c_up_d = 1'b1;
                    grant_d  = GntRmt;
                end
            end else if (pend_eff[BPsgUp]) begin
                s_c_up_d       = 1'b1;
                grant_d        = GntPsg;
                pend_d[BPsgUp] = 1'b0;
            end else begin
                s_c_down_d     = 1'b1;
                grant_d        = GntPsg;
                pend_d[BPsgDn] = 1'b0;
            end
        end

        if (state_q != StLockout) begin
            pend_d = pend_d | rise;
        end
        if (bus.child_lock) begin
            pend_d = pend_d & ~PsgMask;
        end
        // Contradictory up+down requests from one panel cancel each other.
        if (pend_d[BDrvUp] && pend_d[BDrvDn]) begin
            pend_d[BDrvUp] = 1'b0;
            pend_d[BDrvDn] = 1'b0;
        end
        if (pend_d[BPsgUp] && pend_d[BPsgDn]) begin
            pend_d[BPsgUp] = 1'b0;
            pend_d[BPsgDn] = 1'b0;
        end

        // Pinch overrides everything decided above, including a pending pulse.
        if (pinch) begin
            state_d    = StLockout;
            lock_cnt_d = '0;
            pend_d     = '0;
            s_c_up_d   = 1'b0;
            s_c_down_d = 1'b0;
            grant_d    = GntNone;
        end

        pinch_lock_d = (state_d == StLockout);
        busy_d       = (state_d != StIdle);
    end

    // State, synchronizer, debouncer and output registers.
    always_ff @(posedge SYSCLK or negedge RST_N) begin
        if (!RST_N) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            deb_q        <= '0;
            deb_prev_q   <= '0;
            for (int i = 0; i < NumBtn; i++) begin
                cnt_q[i] <= '0;
            end
            pend_q       <= '0;
            stop_s1_q    <= 1'b0;
            stop_s2_q    <= 1'b0;
            stop_prev_q  <= 1'b0;
            state_q      <= StIdle;
            gap_cnt_q    <= '0;
            lock_cnt_q   <= '0;
            s_c_up_q     <= 1'b0;
            s_c_down_q   <= 1'b0;
            grant_q      <= GntNone;
            pinch_lock_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            deb_q        <= deb_d;
            deb_prev_q   <= deb_prev_d;
            for (int i = 0; i < NumBtn; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            pend_q       <= pend_d;
            stop_s1_q    <= stop_s1_d;
            stop_s2_q    <= stop_s2_d;
            stop_prev_q  <= stop_prev_d;
            state_q      <= state_d;
            gap_cnt_q    <= gap_cnt_d;
            lock_cnt_q   <= lock_cnt_d;
            s_c_up_q     <= s_c_up_d;
            s_c_down_q   <= s_c_down_d;
            grant_q      <= grant_d;
            pinch_lock_q <= pinch_lock_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.s_c_up     = s_c_up_q;
    assign bus.s_c_down   = s_c_down_q;
    assign bus.grant      = grant_q;
    assign bus.pinch_lock = pinch_lock_q;
    assign bus.busy       = busy_q;

endmodule
